// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the round-robin grant arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] k);
    return NUM_REQ'(1) << k;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit starting at ptr, wrapping mod NUM_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0]   w_cand [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot;

  // w_rot[gi] is the request that sits gi places after ptr in search order
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign w_cand[gi] = ptr + SEL_W'(gi);
      assign w_rot[gi]  = req[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        idx   = w_cand[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter producing registered one-hot gnt, mux sel and busy.
// Optional per-owner burst limit compiled in with ARB_BURST_LIMIT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  generate
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("MAX_BURST must be in 1..15");
    end
  endgenerate

  arb_state_e         r_state, w_state_next;
  logic [SEL_W-1:0]   r_ptr, w_ptr_next;
  logic [SEL_W-1:0]   r_sel, w_sel_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic               r_busy, w_busy_next;
  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_limit_hit;
  logic               w_rearb;

`ifdef ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  assign w_limit_hit = (r_cnt >= CNT_W'(MAX_BURST));
`else
  assign w_limit_hit = 1'b0;
`endif

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_sel   <= w_sel_next;
      r_gnt   <= w_gnt_next;
      r_busy  <= w_busy_next;
`ifdef ARB_BURST_LIMIT_EN
      r_cnt   <= w_cnt_next;
`endif
    end
  end

  // ptr already points past the owner, so the owner itself is searched last
  assign w_rearb = (r_state == IDLE) || !req[r_sel] || w_limit_hit;

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_sel_next   = r_sel;
    w_gnt_next   = r_gnt;
    w_busy_next  = r_busy;
`ifdef ARB_BURST_LIMIT_EN
    w_cnt_next   = r_cnt;
`endif
    if (w_rearb) begin
      if (w_pick_found) begin
        w_state_next = GRANT;
        w_sel_next   = w_pick_idx;
        w_ptr_next   = w_pick_idx + SEL_W'(1);
        w_gnt_next   = onehot(w_pick_idx);
        w_busy_next  = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        w_cnt_next   = CNT_W'(1);
`endif
      end else begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
        w_busy_next  = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
        w_cnt_next   = '0;
`endif
      end
    end else begin
`ifdef ARB_BURST_LIMIT_EN
      if (r_cnt != {CNT_W{1'b1}}) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
`endif
    end
  end

  always_comb begin
    gnt  = r_gnt;
    sel  = r_sel;
    busy = r_busy;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, directed sequences, random vs. reference model.
module tb_mux_rr_arbiter;

  localparam int MAX_BURST = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int WAIT_BOUND = 3 * MAX_BURST + 3;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  mux_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  // Reference model: owner index (-1 = nobody), search start, grant-run length
  int m_owner;
  int m_ptr;
  int m_run;
  int m_sel;

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_run   = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] q);
    bit rearb;
    int found;
    if (r) begin
      model_reset();
      return;
    end
    rearb = (m_owner < 0) || !q[m_owner] || (LIMIT && m_run >= MAX_BURST);
    if (!rearb) begin
      m_run = (m_run < 15) ? m_run + 1 : 15;
      return;
    end
    found = -1;
    for (int o = 0; o < 4; o++) begin
      if (found < 0 && q[(m_ptr + o) % 4]) found = (m_ptr + o) % 4;
    end
    if (found >= 0) begin
      m_owner = found;
      m_sel   = found;
      m_ptr   = (found + 1) % 4;
      m_run   = 1;
    end else begin
      m_owner = -1;
      m_run   = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%b req=%b gnt=%b sel=%0d busy=%b", n_txn, rst, req, gnt, sel, busy);
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    n_vec++;
    if (gnt !== eg || sel !== es || busy !== eb) begin
      n_err++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=%0d busy=%b",
               name, gnt, sel, busy, eg, es, eb);
    end
  endtask

  vec_t vecs [13];
  int   wait_cnt [4];

  initial begin
    // Short bursts only, so the table holds with or without the burst limit
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[6]  = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[10] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      rst = vecs[v].rst;
      req = vecs[v].req;
      tick();
      check($sformatf("table[%0d]", v), vecs[v].gnt, vecs[v].sel, vecs[v].busy);
    end

    // Two requesters held: alternate every MAX_BURST cycles only when limited
    rst = 1'b1; req = 4'b0101; tick();
    check("burst_reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 3 * MAX_BURST; c++) begin
      bit first;
      tick();
      first = !LIMIT || (((c - 1) / MAX_BURST) % 2 == 0);
      check($sformatf("burst_c%0d", c), first ? 4'b0001 : 4'b0100, first ? 2'd0 : 2'd2, 1'b1);
    end

    // All four requesting, each owner releases after two grant cycles
    rst = 1'b1; req = 4'b1111; tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        tick();
        check($sformatf("rr_k%0d_j%0d", k, j), 4'b0001 << k, 2'(k), 1'b1);
      end
      req[k] = 1'b0;
    end
    tick();
    check("rr_idle", 4'b0000, 2'd3, 1'b0);

    // Lone requester keeps the grant continuously across burst expiries
    req = 4'b1000;
    for (int c = 0; c < 3 * MAX_BURST; c++) begin
      tick();
      check($sformatf("lone_c%0d", c), 4'b1000, 2'd3, 1'b1);
    end

    // Mid-burst reset drops the grant; search restarts from index 0
    rst = 1'b1; tick();
    check("midreset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; req = 4'b1010; tick();
    check("post_reset", 4'b0010, 2'd1, 1'b1);

    // Random phase against the reference model
    rst = 1'b1; req = 4'b0000;
    model_step(rst, req);
    tick();
    check("rand_reset", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] nreq;
      nreq = req;
      for (int i = 0; i < 4; i++) begin
        if (!nreq[i] && $urandom_range(3) == 0) nreq[i] = 1'b1;
        else if (nreq[i] && m_owner == i && ($urandom_range(2) == 0 || m_run >= MAX_BURST))
          nreq[i] = 1'b0;
      end
      rst = ($urandom_range(499) == 0);
      req = nreq;
      model_step(rst, req);
      tick();
      check($sformatf("rand_c%0d", c), (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner),
            2'(m_sel), m_owner >= 0);
      for (int i = 0; i < 4; i++) begin
        if (rst || !req[i] || gnt[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
      end
      n_vec++;
      if (wait_cnt[0] > WAIT_BOUND || wait_cnt[1] > WAIT_BOUND ||
          wait_cnt[2] > WAIT_BOUND || wait_cnt[3] > WAIT_BOUND) begin
        n_err++;
        $display("FAIL starve_c%0d: waits=%0d/%0d/%0d/%0d, want <= %0d",
                 c, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3], WAIT_BOUND);
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
